// File: rtl/mp3.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback in one clock.
// Latency: one instruction retired per clock; loads/stores use same-cycle combinational caches.
// Backpressure: none; caches must answer within the cycle, the core never stalls.
module mp3 (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] icache_address,
   output logic [31:0] icache_wdata,
   input  logic [31:0] icache_rdata,
   output logic        icache_read,
   output logic        icache_write,
   output logic [31:0] dcache_address,
   output logic [31:0] dcache_wdata,
   input  logic [31:0] dcache_rdata,
   output logic        dcache_read,
   output logic        dcache_write
);

   localparam logic [31:0] RESET_PC = 32'h0000_0060;
   localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
   localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

   logic [31:0] pc;
   logic [31:0] rf [32];

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v, alu_b, alu_res, mem_addr, load_v, wb_v, next_pc;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        is_load, is_store, br_taken, rd_we;

   assign instr  = icache_rdata;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // x0 is never written, so reading it always yields the reset value of zero
   assign rs1_v = rf[rs1];
   assign rs2_v = rf[rs2];

   assign is_load  = (opcode == OP_LD);
   assign is_store = (opcode == OP_ST);

   assign icache_address = pc;
   assign icache_wdata   = 32'b0;
   assign icache_read    = 1'b1;
   assign icache_write   = 1'b0;

   assign mem_addr       = rs1_v + (is_store ? imm_s : imm_i);
   assign dcache_address = {mem_addr[31:2], 2'b00};
   // Reset gates memory strobes combinationally so nothing commits while rst is low
   assign dcache_read    = rst & (is_load | is_store);
   assign dcache_write   = rst & is_store;

   // ALU for OP and OP-IMM; instr[30] selects SUB only for register form, SRA for both
   always_comb begin
      alu_b   = (opcode == OP_REG) ? rs2_v : imm_i;
      alu_res = 32'b0;
      case (f3)
         3'b000:  alu_res = (opcode == OP_REG && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
         3'b001:  alu_res = rs1_v << alu_b[4:0];
         3'b010:  alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
         3'b011:  alu_res = {31'b0, rs1_v < alu_b};
         3'b100:  alu_res = rs1_v ^ alu_b;
         3'b101:  alu_res = instr[30] ? $unsigned($signed(rs1_v) >>> alu_b[4:0])
                                      : rs1_v >> alu_b[4:0];
         3'b110:  alu_res = rs1_v | alu_b;
         default: alu_res = rs1_v & alu_b;
      endcase
   end

   // Branch condition evaluation
   always_comb begin
      br_taken = 1'b0;
      case (f3)
         3'b000:  br_taken = (rs1_v == rs2_v);
         3'b001:  br_taken = (rs1_v != rs2_v);
         3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
         3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110:  br_taken = (rs1_v < rs2_v);
         3'b111:  br_taken = (rs1_v >= rs2_v);
         default: br_taken = 1'b0;
      endcase
   end

   // Load lane extraction and extension; misaligned halfwords use bit 1 only
   always_comb begin
      ld_byte = dcache_rdata[7:0];
      case (mem_addr[1:0])
         2'b00:   ld_byte = dcache_rdata[7:0];
         2'b01:   ld_byte = dcache_rdata[15:8];
         2'b10:   ld_byte = dcache_rdata[23:16];
         default: ld_byte = dcache_rdata[31:24];
      endcase
      ld_half = mem_addr[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];
      case (f3)
         3'b000:  load_v = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_v = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_v = {24'b0, ld_byte};
         3'b101:  load_v = {16'b0, ld_half};
         default: load_v = dcache_rdata;
      endcase
   end

   // Store merge: read-modify-write of the addressed byte or halfword
   always_comb begin
      dcache_wdata = dcache_rdata;
      case (f3)
         3'b000:
            case (mem_addr[1:0])
               2'b00:   dcache_wdata[7:0]   = rs2_v[7:0];
               2'b01:   dcache_wdata[15:8]  = rs2_v[7:0];
               2'b10:   dcache_wdata[23:16] = rs2_v[7:0];
               default: dcache_wdata[31:24] = rs2_v[7:0];
            endcase
         3'b001:
            if (mem_addr[1]) dcache_wdata[31:16] = rs2_v[15:0];
            else             dcache_wdata[15:0]  = rs2_v[15:0];
         default: dcache_wdata = rs2_v;
      endcase
   end

   // Writeback selection and next-PC; unknown opcodes fall through as NOPs
   always_comb begin
      wb_v    = alu_res;
      rd_we   = 1'b0;
      next_pc = pc + 32'd4;
      case (opcode)
         OP_LUI:   begin wb_v = imm_u;        rd_we = 1'b1; end
         OP_AUIPC: begin wb_v = pc + imm_u;   rd_we = 1'b1; end
         OP_JAL:   begin wb_v = pc + 32'd4;   rd_we = 1'b1; next_pc = pc + imm_j; end
         OP_JALR:  begin wb_v = pc + 32'd4;   rd_we = 1'b1;
                         next_pc = (rs1_v + imm_i) & 32'hFFFF_FFFE; end
         OP_BR:    if (br_taken) next_pc = pc + imm_b;
         OP_LD:    begin wb_v = load_v;       rd_we = 1'b1; end
         OP_IMM,
         OP_REG:   rd_we = 1'b1;
         default:  rd_we = 1'b0;
      endcase
   end

   // PC register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc <= RESET_PC;
      else      pc <= next_pc;
   end

   // Register file write port; writes to x0 are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
      end else if (rd_we && rd != 5'd0) begin
         rf[rd] <= wb_v;
      end
   end

endmodule

// File: tb/tb_mp3.sv
// Directed bench for mp3: supplies one instruction per cycle and checks PC and memory strobes.
// Register contents are observed by storing them and checking dcache_wdata.
// Data memory is a small word array with combinational read and posedge write.
module tb_mp3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] icache_address, icache_wdata, icache_rdata;
   logic        icache_read, icache_write;
   logic [31:0] dcache_address, dcache_wdata, dcache_rdata;
   logic        dcache_read, dcache_write;

   logic [31:0] dmem [256];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mp3 dut (
      .clk(clk), .rst(rst),
      .icache_address(icache_address), .icache_wdata(icache_wdata),
      .icache_rdata(icache_rdata), .icache_read(icache_read), .icache_write(icache_write),
      .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_read(dcache_read), .dcache_write(dcache_write)
   );

   assign dcache_rdata = dmem[dcache_address[9:2]];

   always @(posedge clk) begin
      if (dcache_write) dmem[dcache_address[9:2]] <= dcache_wdata;
   end

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] im;
      im = imm;
      return {im[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] im;
      im = imm;
      return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs1, int rs2, int f3);
      logic [31:0] im;
      im = imm;
      return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, int op);
      return {imm20[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] im;
      im = imm;
      return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
   endfunction

   task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic rd,
                      input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      vec_t v;
      v.instr = instr; v.pc = pc; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_st(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] wdata);
      add(instr, pc, 1'b1, 1'b1, addr, wdata);
   endtask
   task automatic add_op(input logic [31:0] instr, input logic [31:0] pc);
      add(instr, pc, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
      dmem[64] = 32'h1122_3344;
      rst = 1'b0;
      icache_rdata = enc_s(0, 1, 0, 2);

      // ALU group
      add_op(enc_i(-1, 0, 0, 1, 7'h13),         32'h60);
      add_op(enc_i(28, 1, 5, 2, 7'h13),         32'h64);
      add_op(enc_i(12'h404, 1, 5, 3, 7'h13),    32'h68);
      add_op(enc_r(0, 1, 0, 3, 4),              32'h6C);
      add_op(enc_i(5, 0, 0, 0, 7'h13),          32'h70);
      add_st(enc_s(0, 1, 0, 2),  32'h74, 32'h00, 32'hFFFF_FFFF);
      add_st(enc_s(4, 2, 0, 2),  32'h78, 32'h04, 32'h0000_000F);
      add_st(enc_s(8, 3, 0, 2),  32'h7C, 32'h08, 32'hFFFF_FFFF);
      add_st(enc_s(12, 4, 0, 2), 32'h80, 32'h0C, 32'h0000_0001);
      add_st(enc_s(16, 0, 0, 2), 32'h84, 32'h10, 32'h0000_0000);
      // Load/store lanes
      add_op(enc_i(12'h100, 0, 0, 5, 7'h13),    32'h88);
      add_op(enc_i(12'h0AB, 0, 0, 6, 7'h13),    32'h8C);
      add_st(enc_s(1, 6, 5, 0),  32'h90, 32'h100, 32'h1122_AB44);
      add(enc_i(1, 5, 0, 7, 7'h03), 32'h94, 1'b1, 1'b0, 32'h100, 32'h0);
      add(enc_i(1, 5, 4, 9, 7'h03), 32'h98, 1'b1, 1'b0, 32'h100, 32'h0);
      add(enc_i(2, 5, 1, 8, 7'h03), 32'h9C, 1'b1, 1'b0, 32'h100, 32'h0);
      add_st(enc_s(32, 7, 0, 2), 32'hA0, 32'h20, 32'hFFFF_FFAB);
      add_st(enc_s(36, 9, 0, 2), 32'hA4, 32'h24, 32'h0000_00AB);
      add_st(enc_s(40, 8, 0, 2), 32'hA8, 32'h28, 32'h0000_1122);
      add_st(enc_s(2, 6, 5, 1),  32'hAC, 32'h100, 32'h00AB_AB44);
      // Branches and jumps
      add_op(enc_b(8, 0, 0, 0),                 32'hB0);
      add_op(enc_b(8, 0, 0, 1),                 32'hB8);
      add_op(enc_b(8, 1, 4, 4),                 32'hBC);
      add_op(enc_b(8, 1, 4, 6),                 32'hC4);
      add_op(enc_b(8, 4, 1, 5),                 32'hC8);
      add_op(enc_b(8, 4, 1, 7),                 32'hD0);
      add_op(enc_j(-4, 10),                     32'hD4);
      add_st(enc_s(44, 10, 0, 2), 32'hD0, 32'h2C, 32'h0000_00D8);
      add_op(enc_i(12'h100, 0, 0, 11, 7'h13),   32'hD4);
      add_op(enc_i(3, 11, 0, 12, 7'h67),        32'hD8);
      add_st(enc_s(48, 12, 0, 2), 32'h102, 32'h30, 32'h0000_00DC);
      // Upper immediates, NOP, register ALU
      add_op(enc_u(1, 13, 7'h17),               32'h106);
      add_op(enc_u(20'h12345, 14, 7'h37),       32'h10A);
      add_st(enc_s(52, 13, 0, 2), 32'h10E, 32'h34, 32'h0000_1106);
      add_st(enc_s(56, 14, 0, 2), 32'h112, 32'h38, 32'h1234_5000);
      add_op(32'h0000_0073,                     32'h116);
      add_op(enc_r(7'h20, 4, 1, 0, 15),         32'h11A);
      add_op(enc_r(0, 2, 4, 1, 16),             32'h11E);
      add_op(enc_r(0, 4, 1, 2, 17),             32'h122);
      add_st(enc_s(60, 15, 0, 2), 32'h126, 32'h3C, 32'hFFFF_FFFE);
      add_st(enc_s(64, 16, 0, 2), 32'h12A, 32'h40, 32'h0000_8000);
      add_st(enc_s(68, 17, 0, 2), 32'h12E, 32'h44, 32'h0000_0001);
      // Self-loop
      for (int k = 0; k < 3; k++) add_op(enc_b(0, 0, 0, 0), 32'h132);

      // Reset held with a store on the fetch bus
      repeat (4) @(negedge clk);
      #1;
      check("reset_pc",     icache_address, 32'h60);
      check("reset_dwrite", {31'b0, dcache_write}, 32'h0);
      check("reset_dread",  {31'b0, dcache_read},  32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         icache_rdata = vecs[i].instr;
         #1;
         check($sformatf("v%0d_pc", i),     icache_address, vecs[i].pc);
         check($sformatf("v%0d_dread", i),  {31'b0, dcache_read},  {31'b0, vecs[i].rd});
         check($sformatf("v%0d_dwrite", i), {31'b0, dcache_write}, {31'b0, vecs[i].wr});
         if (vecs[i].rd) check($sformatf("v%0d_daddr", i), dcache_address, vecs[i].addr);
         if (vecs[i].wr) check($sformatf("v%0d_wdata", i), dcache_wdata, vecs[i].wdata);
      end

      // Mid-operation reset discards an in-flight store
      @(negedge clk);
      icache_rdata = enc_s(72, 1, 0, 2);
      #1;
      check("pre_rst_dwrite", {31'b0, dcache_write}, 32'h1);
      rst = 1'b0;
      #1;
      check("mid_rst_pc",     icache_address, 32'h60);
      check("mid_rst_dwrite", {31'b0, dcache_write}, 32'h0);
      @(negedge clk);
      check("mid_rst_nowrite", dmem[18], 32'h0);
      rst = 1'b1;
      #1;
      check("post_rst_pc",    icache_address, 32'h60);
      check("post_rst_x1",    dcache_wdata, 32'h0);
      @(negedge clk);
      icache_rdata = 32'h0000_0013;
      #1;
      check("post_rst_pc2",   icache_address, 32'h64);
      @(negedge clk);
      #1;
      check("post_rst_pc3",   icache_address, 32'h68);

      check("mem_sh_final", dmem[64], 32'h00AB_AB44);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
